// File: rtl/huff_pkg.sv
// huff_pkg: shared constants, FSM state and frequency-entry type for the Huffman encoder stages.
package huff_pkg;
  localparam int NUM_SYMBOLS = 10;
  localparam int NUM_CHARS   = 256;
  localparam int SYM_W       = 4;
  localparam int CNT_W       = 9;
  localparam int ENTRY_W     = SYM_W + CNT_W;
  localparam int FREQ_W      = NUM_SYMBOLS * ENTRY_W;
  localparam int SNAP_W      = NUM_CHARS * SYM_W;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [CNT_W-1:0] cnt;
  } freq_entry_t;
endpackage

// File: rtl/huff_freq_counter.sv
// huff_freq_counter: counts symbol 0..9 occurrences over a 256-nibble snapshot, one nibble per clock.
// Optional HUFF_INVALID_FLAG_EN adds a sticky invalid_seen output for nibbles >= NUM_SYMBOLS.
module huff_freq_counter
  import huff_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              input_over,
  input  logic [SNAP_W-1:0] CHARACTER_IN,
  output logic [FREQ_W-1:0] FREQUENT_OUT,
  output logic              count_over
`ifdef HUFF_INVALID_FLAG_EN
  ,
  output logic              invalid_seen
`endif
);
  state_t state, state_n;
  logic [SNAP_W-1:0] snap;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt [NUM_SYMBOLS];
  logic [SYM_W-1:0] nib;
  logic last;
  logic start;
  assign nib   = snap[SNAP_W-1 -: SYM_W];
  assign last  = idx == CNT_W'(NUM_CHARS - 1);
  assign start = state == IDLE && input_over;
  always_ff @(posedge CLK)
    state <= !nRST ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = start ? SCAN : (state == SCAN && last) ? DONE : state;
  end
  // Snapshot is taken once at start, so later CHARACTER_IN changes cannot disturb the scan.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      idx        <= '0;
      count_over <= 1'b0;
      for (int k = 0; k < NUM_SYMBOLS; k++) cnt[k] <= '0;
    end else if (start) begin
      snap <= CHARACTER_IN;
      idx  <= '0;
    end else if (state == SCAN) begin
      snap <= snap << SYM_W;
      idx  <= idx + 1'b1;
      for (int k = 0; k < NUM_SYMBOLS; k++)
        if (nib == SYM_W'(k)) cnt[k] <= cnt[k] + 1'b1;
      if (last) count_over <= 1'b1;
    end
  end
`ifdef HUFF_INVALID_FLAG_EN
  always_ff @(posedge CLK)
    if (!nRST) invalid_seen <= 1'b0;
    else if (state == SCAN && nib >= SYM_W'(NUM_SYMBOLS)) invalid_seen <= 1'b1;
`endif
  for (genvar g = 0; g < NUM_SYMBOLS; g++) begin : g_out
    assign FREQUENT_OUT[g*ENTRY_W +: ENTRY_W] = freq_entry_t'{sym: SYM_W'(g), cnt: cnt[g]};
  end
endmodule

// File: tb/tb_huff_freq_counter.sv
// tb_huff_freq_counter: scoreboard bench; expected tables are queued at scan start and checked when count_over rises.
module tb_huff_freq_counter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic input_over = 1'b0;
  logic [1023:0] CHARACTER_IN = '0;
  logic [129:0] FREQUENT_OUT;
  logic count_over;
`ifdef HUFF_INVALID_FLAG_EN
  logic invalid_seen;
`endif
  huff_freq_counter dut (
    .CLK(CLK),
    .nRST(nRST),
    .input_over(input_over),
    .CHARACTER_IN(CHARACTER_IN),
    .FREQUENT_OUT(FREQUENT_OUT),
    .count_over(count_over)
`ifdef HUFF_INVALID_FLAG_EN
    ,
    .invalid_seen(invalid_seen)
`endif
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int n_chk = 0;
  int n_pass = 0;
  int start_cyc = 0;
  logic prev_co = 1'b0;
  logic [129:0] exp_q[$];
  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask
  function automatic logic [129:0] pack(input logic [9:0][8:0] c);
    logic [129:0] r;
    for (int k = 0; k < 10; k++) r[13*k +: 13] = {4'(k), c[k]};
    return r;
  endfunction
  function automatic logic [9:0][8:0] one(input int s, input int n);
    logic [9:0][8:0] c;
    c = '0;
    c[s] = 9'(n);
    return c;
  endfunction
  function automatic logic [1023:0] fill(input logic [3:0] a, input logic [3:0] b, input int split);
    logic [1023:0] r;
    for (int i = 0; i < 256; i++) r[1023-4*i -: 4] = (i < split) ? a : b;
    return r;
  endfunction
  function automatic logic [1023:0] ramp();
    logic [1023:0] r;
    for (int i = 0; i < 256; i++) r[1023-4*i -: 4] = 4'(i % 10);
    return r;
  endfunction
  // Monitor: every rising count_over must match the oldest queued table, 256 edges after its start.
  always @(negedge CLK) begin
    if (count_over && !prev_co) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got count_over=1, want no completion pending");
      end else begin
        check("freq_table", FREQUENT_OUT, exp_q.pop_front());
        check("latency", 130'(cyc - start_cyc), 130'(256));
      end
    end
    prev_co = count_over;
  end
  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    input_over = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("reset_freq", FREQUENT_OUT, pack('0));
    check("reset_done", 130'(count_over), 130'(0));
  endtask
  task automatic start(input logic [1023:0] d);
    @(negedge CLK);
    CHARACTER_IN = d;
    input_over = 1'b1;
    start_cyc = cyc + 1;
  endtask
  task automatic wait_done(input string name);
    int t = 0;
    while (!count_over && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!count_over) begin
      n_chk++;
      $display("FAIL %s_timeout: got count_over=0, want 1 within 300 cycles", name);
    end
  endtask
  initial begin
    do_reset();
    start(fill(4'd3, 4'd3, 256));
    exp_q.push_back(pack(one(3, 256)));
    @(negedge CLK);
    input_over = 1'b0;
    wait_done("case1");
    input_over = 1'b1;
    repeat (50) @(negedge CLK);
    check("hold_freq", FREQUENT_OUT, pack(one(3, 256)));
    check("hold_done", 130'(count_over), 130'(1));
    input_over = 1'b0;
`ifdef HUFF_INVALID_FLAG_EN
    check("case1_invalid", 130'(invalid_seen), 130'(0));
`endif
    do_reset();
    start(ramp());
    exp_q.push_back(pack({{4{9'd25}}, {6{9'd26}}}));
    @(negedge CLK);
    input_over = 1'b0;
    repeat (255) @(negedge CLK);
    check("case2_edge255", 130'(count_over), 130'(0));
    @(negedge CLK);
    check("case2_edge256", 130'(count_over), 130'(1));
    do_reset();
    start(fill(4'hF, 4'hF, 256));
    exp_q.push_back(pack('0));
    @(negedge CLK);
    input_over = 1'b0;
    wait_done("case3");
`ifdef HUFF_INVALID_FLAG_EN
    check("case3_invalid", 130'(invalid_seen), 130'(1));
`endif
    do_reset();
    start(fill(4'd7, 4'hC, 128));
    exp_q.push_back(pack(one(7, 128)));
    @(negedge CLK);
    input_over = 1'b0;
    CHARACTER_IN = '0;
    wait_done("case4");
    do_reset();
    start(fill(4'd3, 4'd3, 256));
    @(negedge CLK);
    input_over = 1'b0;
    repeat (99) @(negedge CLK);
    check("case5_partial", FREQUENT_OUT, pack(one(3, 99)));
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("case5_rst_freq", FREQUENT_OUT, pack('0));
    check("case5_rst_done", 130'(count_over), 130'(0));
    start(fill(4'd3, 4'd3, 256));
    exp_q.push_back(pack(one(3, 256)));
    @(negedge CLK);
    input_over = 1'b0;
    wait_done("case5");
    repeat (5) @(negedge CLK);
    check("queue_drained", 130'(exp_q.size()), 130'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
